// File: rtl/pong_game_ctrl.sv
// Pong game-state controller and score keeper.
// Tracks per-player BCD scores, the serving side and the game phase. It drives
// the freeze flag for the graphics stage and the text-region enables for the
// overlay stage. Phase outputs are decoded from the registered state.
module pong_game_ctrl #(
  parameter int WIN_SCORE  = 10,
  parameter int WAIT_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_60hz,
  input  logic       start,
  input  logic       miss_a,
  input  logic       miss_b,
  output logic [3:0] dig0_A,
  output logic [3:0] dig1_A,
  output logic [3:0] dig0_B,
  output logic [3:0] dig1_B,
  output logic [1:0] ball,
  output logic       graph_still,
  output logic [3:0] text_en,
  output logic       game_over
);

  localparam int TW = (WAIT_TICKS < 2) ? 1 : $clog2(WAIT_TICKS + 1);
  localparam logic [TW-1:0] WAIT_LD  = TW'(WAIT_TICKS);
  localparam logic [3:0]    WIN_ONES = 4'(WIN_SCORE % 10);
  localparam logic [3:0]    WIN_TENS = 4'(WIN_SCORE / 10);
  localparam logic [7:0]    WIN_BCD  = {WIN_TENS, WIN_ONES};

  typedef enum logic [1:0] {
    S_NEWGAME = 2'd0,
    S_PLAY    = 2'd1,
    S_NEWBALL = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  state_t        r_state;
  logic [7:0]    r_score_a;
  logic [7:0]    r_score_b;
  logic [1:0]    r_ball;
  logic [TW-1:0] r_timer;
  logic          r_start_q;
  logic          r_start_armed;

  state_t        w_state_nxt;
  logic [7:0]    w_score_a_nxt;
  logic [7:0]    w_score_b_nxt;
  logic [1:0]    w_ball_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [7:0]    w_a_inc;
  logic [7:0]    w_b_inc;
  logic          w_start_rise;
  logic          w_timer_done;

  assign w_a_inc      = bcd_inc(r_score_a);
  assign w_b_inc      = bcd_inc(r_score_b);
  assign w_timer_done = (r_timer == '0);
  // The armed bit needs one sampled low level after reset, so a button held
  // through reset cannot register as a press on release.
  assign w_start_rise = start & ~r_start_q & r_start_armed;

  // Start-button edge detector registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q     <= 1'b0;
      r_start_armed <= 1'b0;
    end else begin
      r_start_q     <= start;
      r_start_armed <= r_start_armed | ~start;
    end
  end

  // Game state, scores, serve side and wait timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_NEWGAME;
      r_score_a <= 8'h00;
      r_score_b <= 8'h00;
      r_ball    <= 2'b00;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_score_a <= w_score_a_nxt;
      r_score_b <= w_score_b_nxt;
      r_ball    <= w_ball_nxt;
      r_timer   <= w_timer_nxt;
    end
  end

  // Next-state logic: scoring, serve selection and timer loading on NEWBALL/OVER entry.
  always_comb begin
    w_state_nxt   = r_state;
    w_score_a_nxt = r_score_a;
    w_score_b_nxt = r_score_b;
    w_ball_nxt    = r_ball;
    w_timer_nxt   = (tick_60hz && !w_timer_done) ? (r_timer - TW'(1)) : r_timer;
    case (r_state)
      S_NEWGAME: begin
        if (w_start_rise) begin
          w_score_a_nxt = 8'h00;
          w_score_b_nxt = 8'h00;
          w_ball_nxt    = 2'b01;
          w_state_nxt   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (miss_a && miss_b) begin
          w_state_nxt = S_NEWBALL;
          w_timer_nxt = WAIT_LD;
        end else if (miss_b) begin
          w_score_a_nxt = w_a_inc;
          w_timer_nxt   = WAIT_LD;
          if (w_a_inc == WIN_BCD) begin
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt = S_NEWBALL;
            w_ball_nxt  = 2'b10;
          end
        end else if (miss_a) begin
          w_score_b_nxt = w_b_inc;
          w_timer_nxt   = WAIT_LD;
          if (w_b_inc == WIN_BCD) begin
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt = S_NEWBALL;
            w_ball_nxt  = 2'b01;
          end
        end
      end
      S_NEWBALL: begin
        if (w_timer_done && w_start_rise) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_OVER: begin
        if (w_timer_done) begin
          w_state_nxt = S_NEWGAME;
        end
      end
      default: w_state_nxt = S_NEWGAME;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    graph_still = 1'b1;
    text_en     = 4'b1110;
    game_over   = 1'b0;
    ball        = 2'b00;
    case (r_state)
      S_PLAY: begin
        graph_still = 1'b0;
        text_en     = 4'b1000;
        ball        = r_ball;
      end
      S_NEWBALL: begin
        text_en = 4'b1000;
        ball    = r_ball;
      end
      S_OVER: begin
        text_en   = 4'b1101;
        game_over = 1'b1;
      end
      default: ;
    endcase
  end

  assign dig0_A = r_score_a[3:0];
  assign dig1_A = r_score_a[7:4];
  assign dig0_B = r_score_b[3:0];
  assign dig1_B = r_score_b[7:4];

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl using an expected-value queue.
module tb_pong_game_ctrl;

  localparam int NG = 0;
  localparam int PL = 1;
  localparam int NB = 2;
  localparam int OV = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_60hz = 1'b0;
  logic       start = 1'b0;
  logic       miss_a = 1'b0;
  logic       miss_b = 1'b0;
  logic [3:0] dig0_A, dig1_A, dig0_B, dig1_B;
  logic [1:0] ball;
  logic       graph_still;
  logic [3:0] text_en;
  logic       game_over;

  int checks = 0;
  int failures = 0;

  // Bench-side game model state.
  int         m_sa = 0;
  int         m_sb = 0;
  logic [1:0] m_ball = 2'b00;

  typedef struct {
    logic [23:0] v;
    string       name;
  } exp_t;
  exp_t sb[$];

  logic [23:0] obs;
  assign obs = {dig1_A, dig0_A, dig1_B, dig0_B, ball, graph_still, text_en, game_over};

  pong_game_ctrl #(.WIN_SCORE(10), .WAIT_TICKS(120)) dut (
    .clk(clk), .reset_n(reset_n), .tick_60hz(tick_60hz), .start(start),
    .miss_a(miss_a), .miss_b(miss_b),
    .dig0_A(dig0_A), .dig1_A(dig1_A), .dig0_B(dig0_B), .dig1_B(dig1_B),
    .ball(ball), .graph_still(graph_still), .text_en(text_en), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input int sa, input int sbv, input logic [1:0] bl, input int st);
    logic [3:0] te;
    logic [1:0] b;
    if (st == NG) te = 4'b1110;
    else if (st == OV) te = 4'b1101;
    else te = 4'b1000;
    b = (st == NG || st == OV) ? 2'b00 : bl;
    return {4'(sa / 10), 4'(sa % 10), 4'(sbv / 10), 4'(sbv % 10), b,
            1'(st != PL), te, 1'(st == OV)};
  endfunction

  task automatic push(input logic [23:0] v, input string n);
    exp_t e;
    e.v = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic go(input logic t, input logic s, input logic ma, input logic mb);
    tick_60hz = t; start = s; miss_a = ma; miss_b = mb;
    @(posedge clk);
    #1;
    tick_60hz = 1'b0; miss_a = 1'b0; miss_b = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      go(1'b1, start, 1'b0, 1'b0);
      go(1'b0, start, 1'b0, 1'b0);
    end
  endtask

  task automatic score_a();
    go(1'b0, 1'b0, 1'b0, 1'b1);
    tick_n(120);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    m_sa++;
    m_ball = 2'b10;
  endtask

  task automatic score_b();
    go(1'b0, 1'b0, 1'b1, 1'b0);
    tick_n(120);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    m_sb++;
    m_ball = 2'b01;
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; start = 1'b0;
    push(mk(0, 0, 2'b00, NG), "reset_hold");
    go(1'b0, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    reset_n = 1'b1;
    push(mk(0, 0, 2'b00, NG), "reset_release");
    go(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
  endtask

  task automatic test_start();
    exp_t e;
    m_sa = 0; m_sb = 0; m_ball = 2'b01;
    push(mk(0, 0, m_ball, PL), "start_to_play");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_miss_newball();
    exp_t e;
    m_sa = 1; m_ball = 2'b10;
    push(mk(m_sa, m_sb, m_ball, NB), "miss_b_scores_a");
    go(1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    tick_n(50);
    push(mk(m_sa, m_sb, m_ball, NB), "start_at_50_ignored");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(69);
    push(mk(m_sa, m_sb, m_ball, NB), "start_at_119_ignored");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(1);
    push(mk(m_sa, m_sb, m_ball, NB), "no_remembered_start");
    go(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, PL), "start_at_120_play");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_win();
    exp_t e;
    while (m_sa < 9) score_a();
    push(mk(9, m_sb, m_ball, PL), "a_at_09");
    go(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    m_sa = 10;
    push(mk(m_sa, m_sb, m_ball, OV), "wrap_to_10_over");
    go(1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    tick_n(119);
    push(mk(m_sa, m_sb, m_ball, OV), "over_last_tick");
    go(1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, NG), "over_to_newgame");
    go(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, NG), "miss_a_in_newgame");
    go(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, NG), "miss_b_in_newgame");
    go(1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    m_sa = 0; m_sb = 0; m_ball = 2'b01;
    push(mk(0, 0, m_ball, PL), "restart_clears");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_both_miss();
    exp_t e;
    while (m_sa < 3) score_a();
    while (m_sb < 4) score_b();
    push(mk(m_sa, m_sb, m_ball, NB), "both_miss_no_score");
    go(1'b0, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, NB), "miss_a_in_newball");
    go(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, NB), "miss_b_in_newball");
    go(1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    tick_n(120);
    push(mk(m_sa, m_sb, m_ball, PL), "both_resume_play");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_over_ignore();
    exp_t e;
    while (m_sb < 9) score_b();
    m_sb = 10;
    push(mk(m_sa, m_sb, m_ball, OV), "b_wins_over");
    go(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, OV), "miss_a_in_over");
    go(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(m_sa, m_sb, m_ball, OV), "miss_b_in_over");
    go(1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    tick_n(120);
    push(mk(m_sa, m_sb, m_ball, NG), "b_win_back_newgame");
    go(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    m_sa = 0; m_sb = 0; m_ball = 2'b01;
    go(1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    m_sa = 1; m_ball = 2'b10;
    go(1'b0, 1'b0, 1'b0, 1'b1);
    tick_n(60);
    push(mk(m_sa, m_sb, m_ball, NB), "mid_newball_start_held");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    #2 reset_n = 1'b0;
    #1;
    push(mk(0, 0, 2'b00, NG), "async_reset_immediate");
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(mk(0, 0, 2'b00, NG), "held_start_no_edge");
      go(1'b0, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    end
    push(mk(0, 0, 2'b00, NG), "start_released");
    go(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    push(mk(0, 0, 2'b01, PL), "fresh_press_plays");
    go(1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v); end
    go(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss_newball();
    test_win();
    test_both_miss();
    test_over_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
